// File: rtl/wmemi_pkg.sv
// Shared constants and FSM state type for the WMemI responder.
package wmemi_pkg;
    localparam int ADDR_W = 36;
    localparam int DATA_W = 128;
    localparam int BE_W   = 16;
    localparam int BLEN_W = 12;

    localparam logic [2:0] CMD_IDLE = 3'd0;
    localparam logic [2:0] CMD_WR   = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;

    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_WAIT,
        ST_RD_RESP
    } state_e;
endpackage

// File: rtl/wmemi_mem_array.sv
// Simple dual-port byte-enabled memory, synchronous read, no reset.
module wmemi_mem_array
    import wmemi_pkg::*;
#(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    input  logic [BE_W-1:0]      be_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [DATA_W-1:0]    rdata_o
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/wmemi_responder.sv
// WMemI memory-side responder: burst writes into a small memory and
// returns read bursts as DVA beats after a fixed latency.
module wmemi_responder
    import wmemi_pkg::*;
#(
    parameter int ADDR_BITS = 4,
    parameter int READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        wmemiS_MCmd,
    input  logic              wmemiS_MReqLast,
    input  logic [ADDR_W-1:0] wmemiS_MAddr,
    input  logic [BLEN_W-1:0] wmemiS_MBurstLength,
    input  logic              wmemiS_MDataValid,
    input  logic              wmemiS_MDataLast,
    input  logic [DATA_W-1:0] wmemiS_MData,
    input  logic [BE_W-1:0]   wmemiS_MDataByteEn,
    input  logic              wmemiS_MReset_n,
    output logic [1:0]        wmemiS_SResp,
    output logic              wmemiS_SRespLast,
    output logic [DATA_W-1:0] wmemiS_SData,
    output logic              wmemiS_SCmdAccept,
    output logic              wmemiS_SDataAccept,
    output logic              err
);
    localparam logic [3:0] WAIT_END = 4'(READ_LAT - 2);

    state_e                state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [BLEN_W-1:0]     len_q, len_d;
    logic [BLEN_W-1:0]     beat_q, beat_d;
    logic [3:0]            wait_q, wait_d;
    logic                  err_q, err_d;
    logic                  mem_we;
    logic                  final_beat;
    logic                  resp_act;
    logic [DATA_W-1:0]     rdata;
    logic                  unused;

    assign unused = ^{wmemiS_MReqLast, wmemiS_MAddr[ADDR_W-1:4+ADDR_BITS],
                      wmemiS_MAddr[3:0]};

    assign final_beat = (beat_q == len_q - 12'd1);
    assign resp_act   = reset && (state_q == ST_RD_RESP);

    assign wmemiS_SCmdAccept  = reset && wmemiS_MReset_n && (state_q == ST_IDLE);
    assign wmemiS_SDataAccept = reset && (state_q == ST_WR_DATA);
    assign wmemiS_SResp       = resp_act ? RESP_DVA : RESP_NULL;
    assign wmemiS_SRespLast   = resp_act && final_beat;
    assign wmemiS_SData       = resp_act ? rdata : '0;
    assign err                = reset && err_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (wmemiS_SCmdAccept && wmemiS_MCmd != CMD_IDLE) begin
                    if (wmemiS_MCmd == CMD_WR || wmemiS_MCmd == CMD_RD) begin
                        addr_d = wmemiS_MAddr[4 +: ADDR_BITS];
                        len_d  = (wmemiS_MBurstLength == '0) ? 12'd1
                                                             : wmemiS_MBurstLength;
                        beat_d = '0;
                        wait_d = '0;
                        if (wmemiS_MBurstLength == '0) err_d = 1'b1;
                        if (wmemiS_MCmd == CMD_WR) state_d = ST_WR_DATA;
                        else state_d = (READ_LAT > 1) ? ST_RD_WAIT : ST_RD_RESP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WR_DATA: begin
                if (wmemiS_MDataValid) begin
                    mem_we = reset;
                    addr_d = addr_q + 1'b1;
                    beat_d = beat_q + 12'd1;
                    if (final_beat || wmemiS_MDataLast) begin
                        state_d = ST_IDLE;
                        if (final_beat != wmemiS_MDataLast) err_d = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (wait_q == WAIT_END) state_d = ST_RD_RESP;
                else wait_d = wait_q + 4'd1;
            end
            ST_RD_RESP: begin
                addr_d = addr_q + 1'b1;
                beat_d = beat_q + 12'd1;
                if (final_beat) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Initiator reset aborts whatever burst is in flight.
        if (!wmemiS_MReset_n) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Read address runs one cycle ahead so data lines up with addr_q.
    wmemi_mem_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_mem (
        .clk    (clk),
        .we_i   (mem_we),
        .waddr_i(addr_q),
        .wdata_i(wmemiS_MData),
        .be_i   (wmemiS_MDataByteEn),
        .raddr_i(addr_d),
        .rdata_o(rdata)
    );
endmodule

// File: tb/tb_wmemi_responder.sv
// Bench for wmemi_responder: READ_LAT=1 and READ_LAT=3 instances share
// stimulus and are checked against a word-array reference model.
module tb_wmemi_responder;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [2:0]   mcmd;
    logic         mreqlast;
    logic [35:0]  maddr;
    logic [11:0]  mblen;
    logic         mdv;
    logic         mdlast;
    logic [127:0] mdata;
    logic [15:0]  mbe;
    logic         mrst_n;

    logic [1:0]   sresp [2];
    logic         slast [2];
    logic [127:0] sdata [2];
    logic         cacc  [2];
    logic         dacc  [2];
    logic         errs  [2];

    logic [127:0] model [16];
    logic [127:0] wdat  [32];
    logic [15:0]  wbe   [32];
    bit           err_m;
    int           n_checks = 0;
    int           n_fail = 0;

    wmemi_responder #(.ADDR_BITS(4), .READ_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .wmemiS_MCmd(mcmd), .wmemiS_MReqLast(mreqlast),
        .wmemiS_MAddr(maddr), .wmemiS_MBurstLength(mblen),
        .wmemiS_MDataValid(mdv), .wmemiS_MDataLast(mdlast),
        .wmemiS_MData(mdata), .wmemiS_MDataByteEn(mbe),
        .wmemiS_MReset_n(mrst_n),
        .wmemiS_SResp(sresp[0]), .wmemiS_SRespLast(slast[0]),
        .wmemiS_SData(sdata[0]), .wmemiS_SCmdAccept(cacc[0]),
        .wmemiS_SDataAccept(dacc[0]), .err(errs[0])
    );

    wmemi_responder #(.ADDR_BITS(4), .READ_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .wmemiS_MCmd(mcmd), .wmemiS_MReqLast(mreqlast),
        .wmemiS_MAddr(maddr), .wmemiS_MBurstLength(mblen),
        .wmemiS_MDataValid(mdv), .wmemiS_MDataLast(mdlast),
        .wmemiS_MData(mdata), .wmemiS_MDataByteEn(mbe),
        .wmemiS_MReset_n(mrst_n),
        .wmemiS_SResp(sresp[1]), .wmemiS_SRespLast(slast[1]),
        .wmemiS_SData(sdata[1]), .wmemiS_SCmdAccept(cacc[1]),
        .wmemiS_SDataAccept(dacc[1]), .err(errs[1])
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_in();
        mcmd = 3'd0; mreqlast = 1'b0; maddr = '0; mblen = '0;
        mdv = 1'b0; mdlast = 1'b0; mdata = '0; mbe = '0; mrst_n = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc();
            reset = 1'b0;
            mcmd = 3'd2; maddr = 36'h20; mblen = 12'd4;
            smp();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if ({sresp[d], slast[d], sdata[d], cacc[d], dacc[d], errs[d]} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_outputs dut%0d cyc%0d got resp=%h last=%b acc=%b dacc=%b err=%b data=%h exp all 0",
                             d, i, sresp[d], slast[d], cacc[d], dacc[d], errs[d], sdata[d]);
                end
            end
        end
        err_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            reset = 1'b1;
            smp();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (cacc[d] !== 1'b1 || sresp[d] !== 2'd0 || errs[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL post_reset dut%0d cyc%0d got acc=%b resp=%h err=%b exp acc=1 resp=0 err=0",
                             d, i, cacc[d], sresp[d], errs[d]);
                end
            end
        end
    endtask

    task automatic do_write(input logic [35:0] a, input logic [11:0] bl, input int last_at);
        int len;
        int nb;
        int w0;
        len = (bl == 0) ? 1 : int'(bl);
        nb = (last_at < len) ? last_at + 1 : len;
        w0 = int'(a[7:4]);
        cyc();
        mcmd = 3'd1; maddr = a; mblen = bl;
        mdv = 1'b1; mdata = wdat[0]; mbe = wbe[0]; mdlast = (last_at == 0);
        smp();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (cacc[d] !== 1'b1 || dacc[d] !== 1'b0 || errs[d] !== err_m) begin
                n_fail++;
                $display("FAIL wr_cmd dut%0d got acc=%b dacc=%b err=%b exp acc=1 dacc=0 err=%b",
                         d, cacc[d], dacc[d], errs[d], err_m);
            end
        end
        for (int i = 0; i < nb; i++) begin
            if ($urandom_range(3) == 0) begin
                cyc();
                smp();
            end
            cyc();
            mdv = 1'b1; mdata = wdat[i]; mbe = wbe[i]; mdlast = (i == last_at);
            smp();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (dacc[d] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wr_beat dut%0d beat%0d got dacc=%b exp 1", d, i, dacc[d]);
                end
            end
            for (int b = 0; b < 16; b++) begin
                if (wbe[i][b]) model[(w0 + i) % 16][b*8 +: 8] = wdat[i][b*8 +: 8];
            end
        end
        if (bl == 0 || last_at != len - 1) err_m = 1'b1;
    endtask

    task automatic do_read(input logic [35:0] a, input logic [11:0] bl);
        int len;
        int w0;
        logic [127:0] exp_d [32];
        len = (bl == 0) ? 1 : int'(bl);
        w0 = int'(a[7:4]);
        for (int i = 0; i < len; i++) exp_d[i] = model[(w0 + i) % 16];
        cyc();
        mcmd = 3'd2; maddr = a; mblen = bl;
        smp();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (cacc[d] !== 1'b1 || errs[d] !== err_m) begin
                n_fail++;
                $display("FAIL rd_cmd dut%0d got acc=%b err=%b exp acc=1 err=%b",
                         d, cacc[d], errs[d], err_m);
            end
        end
        if (bl == 0) err_m = 1'b1;
        for (int k = 1; k <= len + 3; k++) begin
            cyc();
            smp();
            for (int d = 0; d < 2; d++) begin
                int lat;
                bit er;
                bit el;
                logic [127:0] ed;
                lat = (d == 0) ? 1 : 3;
                er = (k >= lat) && (k < lat + len);
                el = (k == lat + len - 1);
                ed = '0;
                if (er) ed = exp_d[k - lat];
                n_checks++;
                if (sresp[d] !== {1'b0, er} || slast[d] !== el || sdata[d] !== ed) begin
                    n_fail++;
                    $display("FAIL rd_beat dut%0d k=%0d got resp=%h last=%b data=%h exp resp=%0d last=%b data=%h",
                             d, k, sresp[d], slast[d], sdata[d], er, el, ed);
                end
                if (k == lat + len) begin
                    n_checks++;
                    if (cacc[d] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL rd_done_acc dut%0d k=%0d got acc=%b exp 1", d, k, cacc[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wdat[i] = rnd128();
            wbe[i] = 16'hFFFF;
        end
        do_write(36'h0, 12'd16, 15);
        do_read(36'h0, 12'd16);
    endtask

    task automatic test_burst();
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 128'hA0 + 128'(i);
            wbe[i] = 16'hFFFF;
        end
        do_write(36'h20, 12'd4, 3);
        do_read(36'h20, 12'd4);
    endtask

    task automatic test_byte_en();
        wdat[0] = '1; wbe[0] = 16'hFFFF;
        do_write(36'h50, 12'd1, 0);
        wdat[0] = '0; wbe[0] = 16'h000F;
        do_write(36'h50, 12'd1, 0);
        do_read(36'h50, 12'd1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            wdat[i] = 128'(i + 1);
            wbe[i] = 16'hFFFF;
        end
        do_write(36'hF0, 12'd3, 2);
        do_read(36'h00, 12'd1);
        do_read(36'h10, 12'd1);
        do_read(36'hF0, 12'd3);
    endtask

    task automatic test_zero_len();
        wdat[0] = rnd128(); wbe[0] = 16'hFFFF;
        do_write(36'h70, 12'd0, 0);
        do_read(36'h70, 12'd0);
    endtask

    task automatic test_early_last();
        for (int i = 0; i < 4; i++) begin
            wdat[i] = rnd128();
            wbe[i] = 16'hFFFF;
        end
        do_write(36'h30, 12'd4, 2);
        do_read(36'h30, 12'd4);
        test_reset();
        do_write(36'h90, 12'd2, 5);
        do_read(36'h90, 12'd2);
    endtask

    task automatic test_bad_cmd();
        cyc();
        mcmd = 3'd3; maddr = 36'h40; mblen = 12'd2;
        smp();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (cacc[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL bad_cmd_acc dut%0d got acc=%b exp 1", d, cacc[d]);
            end
        end
        err_m = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            smp();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (sresp[d] !== 2'd0 || cacc[d] !== 1'b1 || errs[d] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bad_cmd_idle dut%0d k=%0d got resp=%h acc=%b err=%b exp resp=0 acc=1 err=1",
                             d, k, sresp[d], cacc[d], errs[d]);
                end
            end
        end
    endtask

    task automatic test_mreset();
        logic [35:0] a;
        logic [127:0] w0d;
        a = 36'($urandom_range(15)) << 4;
        w0d = model[a[7:4]];
        cyc();
        mcmd = 3'd2; maddr = a; mblen = 12'd2;
        smp();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 3) mrst_n = 1'b0;
            smp();
            for (int d = 0; d < 2; d++) begin
                bit er;
                logic [127:0] ed;
                er = (d == 0) ? (k <= 2) : (k == 3);
                ed = '0;
                if (er) ed = (d == 0) ? model[(int'(a[7:4]) + k - 1) % 16] : w0d;
                n_checks++;
                if (sresp[d] !== {1'b0, er} || sdata[d] !== ed) begin
                    n_fail++;
                    $display("FAIL mreset_beat dut%0d k=%0d got resp=%h data=%h exp resp=%0d data=%h",
                             d, k, sresp[d], sdata[d], er, ed);
                end
                if (k >= 3) begin
                    n_checks++;
                    if (cacc[d] !== (k == 4)) begin
                        n_fail++;
                        $display("FAIL mreset_acc dut%0d k=%0d got acc=%b exp %0d", d, k, cacc[d], k == 4);
                    end
                end
            end
        end
        do_read(a, 12'd2);
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [11:0] bl;
            bl = 12'($urandom_range(20, 1));
            for (int i = 0; i < 20; i++) begin
                wdat[i] = rnd128();
                wbe[i] = 16'($urandom);
            end
            do_write({$urandom, 4'($urandom)}, bl, int'(bl) - 1);
            do_read({$urandom, 4'($urandom)}, 12'($urandom_range(20, 1)));
        end
    endtask

    initial begin
        idle_in();
        test_reset();
        test_fill();
        test_burst();
        test_byte_en();
        test_wrap();
        test_zero_len();
        test_reset();
        test_early_last();
        test_reset();
        test_bad_cmd();
        test_mreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
